// File: rtl/ram_pingpong_wr_arb.sv
// Ping-pong write-side arbiter for a dual-half RAM buffer.
// Two requesters stream bytes into the write port. The RAM is split into two
// halves. A granted requester fills a whole half before the next grant is made.
// Completed halves are announced to the read clock domain by a toggle. The
// reader hands a half back with its own toggle, and halves are released in the
// order they were filled.
module ram_pingpong_wr_arb #(
    parameter int RAM_DEPTH      = 64,
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_RD2WR      = 4
) (
    input  logic                      wr_clk,
    input  logic                      rst_n,
    input  logic                      s0_valid,
    input  logic [RAM_DATA_WIDTH-1:0] s0_data,
    output logic                      s0_ready,
    input  logic                      s1_valid,
    input  logic [RAM_DATA_WIDTH-1:0] s1_data,
    output logic                      s1_ready,
    output logic                      ram_wr_port_ena,
    output logic                      ram_wr_en,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_wr_data,
    output logic                      buf_full_tgl,
    output logic                      buf_half,
    output logic                      buf_owner,
    input  logic                      rd_release_tgl,
    output logic [1:0]                buf_cnt,
    output logic                      rel_err
);

    // Half size. The depth is a power of two, so the write address is simply
    // {half index, offset within the half}.
    localparam int HALF  = RAM_DEPTH / 2;
    localparam int CNT_W = RAM_ADDR_WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Reject parameter sets that cannot form two equal power-of-two halves
    // readable in whole read-width words.
    if (RAM_DEPTH != (1 << RAM_ADDR_WIDTH)) begin : g_bad_depth
        $error("RAM_DEPTH must equal 2**RAM_ADDR_WIDTH");
    end
    if ((HALF % RAM_RD2WR) != 0) begin : g_bad_ratio
        $error("RAM_DEPTH/2 must be a multiple of RAM_RD2WR");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Registered state
    state_t                    state_q,           state_d;
    logic                      grant_q,           grant_d;
    logic                      last_grant_q,      last_grant_d;
    logic [CNT_W-1:0]          cnt_q,             cnt_d;
    logic                      wr_half_q,         wr_half_d;
    logic                      rd_half_q,         rd_half_d;
    logic [1:0]                half_valid_q,      half_valid_d;
    logic                      ram_wr_en_q,       ram_wr_en_d;
    logic                      ram_wr_port_ena_q, ram_wr_port_ena_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr_q,     ram_wr_addr_d;
    logic [RAM_DATA_WIDTH-1:0] ram_wr_data_q,     ram_wr_data_d;
    logic                      buf_full_tgl_q,    buf_full_tgl_d;
    logic                      buf_half_q,        buf_half_d;
    logic                      buf_owner_q,       buf_owner_d;
    logic [1:0]                buf_cnt_q,         buf_cnt_d;
    logic                      rel_err_q,         rel_err_d;
    logic                      sync1_q,           sync1_d;
    logic                      sync2_q,           sync2_d;
    logic                      sync3_q,           sync3_d;

    // Combinational helpers
    logic                      hs_s;
    logic                      last_s;
    logic                      rel_edge_s;
    logic [RAM_DATA_WIDTH-1:0] sel_data_s;

    // A byte is accepted only from the granted requester while filling.
    assign hs_s       = (state_q == ST_FILL) && (grant_q ? s1_valid : s0_valid);
    assign last_s     = hs_s && (cnt_q == CNT_LAST);
    assign rel_edge_s = sync2_q ^ sync3_q;
    assign sel_data_s = grant_q ? s1_data : s0_data;

    // Ready is decoded from the registered state and grant, so it can only be high for one requester.
    assign s0_ready = (state_q == ST_FILL) && !grant_q;
    assign s1_ready = (state_q == ST_FILL) &&  grant_q;

    assign ram_wr_en       = ram_wr_en_q;
    assign ram_wr_port_ena = ram_wr_port_ena_q;
    assign ram_wr_addr     = ram_wr_addr_q;
    assign ram_wr_data     = ram_wr_data_q;
    assign buf_full_tgl    = buf_full_tgl_q;
    assign buf_half        = buf_half_q;
    assign buf_owner       = buf_owner_q;
    assign buf_cnt         = buf_cnt_q;
    assign rel_err         = rel_err_q;

    // Next-state logic for the arbiter FSM, the write port, the half bookkeeping and the release synchroniser.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        cnt_d             = cnt_q;
        wr_half_d         = wr_half_q;
        rd_half_d         = rd_half_q;
        half_valid_d      = half_valid_q;
        ram_wr_en_d       = 1'b0;
        ram_wr_port_ena_d = 1'b0;
        ram_wr_addr_d     = ram_wr_addr_q;
        ram_wr_data_d     = ram_wr_data_q;
        buf_full_tgl_d    = buf_full_tgl_q;
        buf_half_d        = buf_half_q;
        buf_owner_d       = buf_owner_q;
        rel_err_d         = rel_err_q;
        sync1_d           = rd_release_tgl;
        sync2_d           = sync1_q;
        sync3_d           = sync2_q;

        // Arbitration: a grant is only made when the target half is free.
        // Once granted, the fill runs to the end of the half.
        case (state_q)
            ST_IDLE: begin
                if (!half_valid_q[wr_half_q] && (s0_valid || s1_valid)) begin
                    state_d = ST_FILL;
                    if (s0_valid && s1_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s1_valid;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (last_s) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write port: one registered write per accepted byte. Address and data hold otherwise.
        if (hs_s) begin
            ram_wr_en_d       = 1'b1;
            ram_wr_port_ena_d = 1'b1;
            ram_wr_addr_d     = {wr_half_q, cnt_q};
            ram_wr_data_d     = sel_data_s;
            if (last_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            ram_wr_en_d       = 1'b0;
            ram_wr_port_ena_d = 1'b0;
        end

        // Release from the reader frees the oldest filled half. With nothing
        // outstanding, the release is only flagged.
        if (rel_edge_s) begin
            if (half_valid_q == 2'b00) begin
                rel_err_d = 1'b1;
            end else begin
                half_valid_d[rd_half_q] = 1'b0;
                rd_half_d               = ~rd_half_q;
            end
        end else begin
            rel_err_d = rel_err_q;
        end

        // Completion publishes the half to the reader and moves on to the other half.
        if (last_s) begin
            half_valid_d[wr_half_q] = 1'b1;
            buf_full_tgl_d          = ~buf_full_tgl_q;
            buf_half_d              = wr_half_q;
            buf_owner_d             = grant_q;
            wr_half_d               = ~wr_half_q;
        end else begin
            buf_full_tgl_d = buf_full_tgl_q;
        end

        buf_cnt_d = {1'b0, half_valid_d[0]} + {1'b0, half_valid_d[1]};
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            grant_q           <= 1'b0;
            last_grant_q      <= 1'b1;
            cnt_q             <= CNT_ZERO;
            wr_half_q         <= 1'b0;
            rd_half_q         <= 1'b0;
            half_valid_q      <= 2'b00;
            ram_wr_en_q       <= 1'b0;
            ram_wr_port_ena_q <= 1'b0;
            ram_wr_addr_q     <= {RAM_ADDR_WIDTH{1'b0}};
            ram_wr_data_q     <= {RAM_DATA_WIDTH{1'b0}};
            buf_full_tgl_q    <= 1'b0;
            buf_half_q        <= 1'b0;
            buf_owner_q       <= 1'b0;
            buf_cnt_q         <= 2'd0;
            rel_err_q         <= 1'b0;
            sync1_q           <= 1'b0;
            sync2_q           <= 1'b0;
            sync3_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            grant_q           <= grant_d;
            last_grant_q      <= last_grant_d;
            cnt_q             <= cnt_d;
            wr_half_q         <= wr_half_d;
            rd_half_q         <= rd_half_d;
            half_valid_q      <= half_valid_d;
            ram_wr_en_q       <= ram_wr_en_d;
            ram_wr_port_ena_q <= ram_wr_port_ena_d;
            ram_wr_addr_q     <= ram_wr_addr_d;
            ram_wr_data_q     <= ram_wr_data_d;
            buf_full_tgl_q    <= buf_full_tgl_d;
            buf_half_q        <= buf_half_d;
            buf_owner_q       <= buf_owner_d;
            buf_cnt_q         <= buf_cnt_d;
            rel_err_q         <= rel_err_d;
            sync1_q           <= sync1_d;
            sync2_q           <= sync2_d;
            sync3_q           <= sync3_d;
        end
    end

endmodule

// File: tb/tb_ram_pingpong_wr_arb.sv
// Directed bench for ram_pingpong_wr_arb: fills, round-robin, release, reset.
module tb_ram_pingpong_wr_arb;

    localparam int HALF = 32;

    logic       wr_clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s1_valid;
    logic [7:0] s0_data, s1_data;
    logic       s0_ready, s1_ready;
    logic       ram_wr_port_ena, ram_wr_en;
    logic [5:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic       buf_full_tgl, buf_half, buf_owner;
    logic       rd_release_tgl;
    logic [1:0] buf_cnt;
    logic       rel_err;

    int tests = 0;
    int fails = 0;

    // Free-running write clock.
    always #5 wr_clk = ~wr_clk;

    ram_pingpong_wr_arb #(
        .RAM_DEPTH(64), .RAM_ADDR_WIDTH(6), .RAM_DATA_WIDTH(8), .RAM_RD2WR(4)
    ) dut (
        .wr_clk(wr_clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .ram_wr_port_ena(ram_wr_port_ena), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .buf_full_tgl(buf_full_tgl), .buf_half(buf_half), .buf_owner(buf_owner),
        .rd_release_tgl(rd_release_tgl), .buf_cnt(buf_cnt), .rel_err(rel_err)
    );

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit who, input bit v, input logic [7:0] d);
        if (who) begin
            s1_valid = v;
            s1_data  = d;
        end else begin
            s0_valid = v;
            s0_data  = d;
        end
    endtask

    // Stream nbytes from requester 'who' (valid on one cycle in 'period'),
    // checking each registered write against base+k / dbase+k and the toggle.
    task automatic stream(input bit who, input bit other_v, input int nbytes, input int base,
                          input int period, input logic [7:0] dbase, input bit t0, input string tag);
        int  k;
        int  c;
        int  waitc;
        bit  v;
        k = 0;
        c = 0;
        waitc = 0;
        drive(who, 1'b1, dbase);
        drive(!who, other_v, 8'hEE);
        do begin
            tick();
            waitc++;
        end while (!(who ? s1_ready : s0_ready) && waitc < 8);
        chk({tag, "_grant"}, 32'(who ? s1_ready : s0_ready), 32'd1);
        if ((who ? s1_ready : s0_ready) === 1'b1) begin
            while (k < nbytes && c < 200) begin
                v = ((c % period) == 0);
                drive(who, v, 8'(dbase + 8'(k)));
                chk({tag, "_rdy"}, 32'(who ? s1_ready : s0_ready), 32'd1);
                chk({tag, "_rdy_other"}, 32'(who ? s0_ready : s1_ready), 32'd0);
                tick();
                if (v) begin
                    chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'd1);
                    chk({tag, "_port_ena"}, 32'(ram_wr_port_ena), 32'd1);
                    chk({tag, "_addr"}, 32'(ram_wr_addr), 32'(base + k));
                    chk({tag, "_data"}, 32'(ram_wr_data), 32'(8'(dbase + 8'(k))));
                    k++;
                end else begin
                    chk({tag, "_idle_wr_en"}, 32'(ram_wr_en), 32'd0);
                    chk({tag, "_idle_port_ena"}, 32'(ram_wr_port_ena), 32'd0);
                end
                chk({tag, "_tgl"}, 32'(buf_full_tgl), 32'((k == HALF) ? !t0 : t0));
                c++;
            end
        end
        chk({tag, "_nbytes"}, 32'(k), 32'(nbytes));
        drive(who, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = 8'h00; s1_data = 8'h00;
        rd_release_tgl = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_port_ena", 32'(ram_wr_port_ena), 32'd0);
        chk("rst_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst_data", 32'(ram_wr_data), 32'd0);
        chk("rst_tgl", 32'(buf_full_tgl), 32'd0);
        chk("rst_cnt", 32'(buf_cnt), 32'd0);
        chk("rst_rel_err", 32'(rel_err), 32'd0);
        chk("rst_rdy", 32'({s0_ready, s1_ready}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Release with nothing outstanding sets the sticky error only
        rd_release_tgl = 1'b1;
        tick(); tick(); tick();
        chk("relerr_set", 32'(rel_err), 32'd1);
        chk("relerr_cnt", 32'(buf_cnt), 32'd0);
        tick();
        chk("relerr_sticky", 32'(rel_err), 32'd1);

        // s0 streams 0x00..0x1F into half 0
        stream(1'b0, 1'b0, 32, 0, 1, 8'h00, 1'b0, "s0fill");
        chk("s0fill_half", 32'(buf_half), 32'd0);
        chk("s0fill_owner", 32'(buf_owner), 32'd0);
        chk("s0fill_cnt", 32'(buf_cnt), 32'd1);
        chk("s0fill_rdy_after", 32'(s0_ready), 32'd0);
        tick();
        chk("hold_wr_en", 32'(ram_wr_en), 32'd0);
        chk("hold_addr", 32'(ram_wr_addr), 32'd31);
        chk("hold_data", 32'(ram_wr_data), 32'h1F);

        // s1 with 1-of-3 duty fills half 1
        stream(1'b1, 1'b0, 32, 32, 3, 8'h40, 1'b1, "s1duty");
        chk("s1duty_half", 32'(buf_half), 32'd1);
        chk("s1duty_owner", 32'(buf_owner), 32'd1);
        chk("s1duty_cnt", 32'(buf_cnt), 32'd2);
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_rdy", 32'({s0_ready, s1_ready}), 32'd0);
            chk("full_wr_en", 32'(ram_wr_en), 32'd0);
        end

        // Release frees half 0 (oldest, despite the earlier stray release); s0 refills, reset after 10 bytes
        rd_release_tgl = 1'b0;
        tick(); tick(); tick();
        chk("rel1_cnt", 32'(buf_cnt), 32'd1);
        chk("rel1_rel_err", 32'(rel_err), 32'd1);
        stream(1'b0, 1'b1, 10, 0, 1, 8'hA0, 1'b0, "partial");
        s0_valid = 1'b0; s1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst2_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst2_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst2_data", 32'(ram_wr_data), 32'd0);
        chk("rst2_half", 32'(buf_half), 32'd0);
        chk("rst2_owner", 32'(buf_owner), 32'd0);
        chk("rst2_cnt", 32'(buf_cnt), 32'd0);
        chk("rst2_rel_err", 32'(rel_err), 32'd0);
        chk("rst2_tgl", 32'(buf_full_tgl), 32'd0);
        rst_n = 1'b1;

        // Both valid: s0 gets half 0 from address 0, then s1 gets half 1
        stream(1'b0, 1'b1, 32, 0, 1, 8'h10, 1'b0, "rrA");
        chk("rrA_half", 32'(buf_half), 32'd0);
        chk("rrA_owner", 32'(buf_owner), 32'd0);
        chk("rrA_cnt", 32'(buf_cnt), 32'd1);
        stream(1'b1, 1'b1, 32, 32, 1, 8'h80, 1'b1, "rrB");
        chk("rrB_half", 32'(buf_half), 32'd1);
        chk("rrB_owner", 32'(buf_owner), 32'd1);
        chk("rrB_cnt", 32'(buf_cnt), 32'd2);
        s1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rr_full_rdy", 32'({s0_ready, s1_ready}), 32'd0);
        end

        // Release half 0; s0 is next by round-robin and restarts at address 0
        rd_release_tgl = 1'b1;
        tick(); tick(); tick();
        chk("rel2_cnt", 32'(buf_cnt), 32'd1);
        chk("rel2_rel_err", 32'(rel_err), 32'd0);
        stream(1'b0, 1'b1, 4, 0, 1, 8'hC0, 1'b0, "refill");
        chk("refill_cnt", 32'(buf_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
